// File: rtl/m_bb.sv
// m_bb: 2x2 multiplier bit brick with per-operand sign selection.
// Leaf cell of the fusible multiplier unit. Each operand is widened to
// three bits according to its sign-select bit, a 3x3 AND array forms the
// partial products, and the terms that carry the operand sign weight are
// subtracted (Baugh-Wooley style) before the low four bits are registered.
module m_bb (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] sel,
    output logic [3:0] p
);

    // Widen a 2-bit operand to 3 bits: sign-extend when s is set, else zero-extend.
    function automatic logic signed [2:0] f_ext(input logic [1:0] v, input logic s);
        return {s & v[1], v};
    endfunction

    // Operands are forced to zero while en=0. p ignores them in that case.
    // The gating stops unknown values from reaching the array when the inputs are idle.
    logic [1:0]        w_a_g;
    logic [1:0]        w_b_g;
    logic [1:0]        w_sel_g;
    logic signed [2:0] w_ax;
    logic signed [2:0] w_bx;
    logic [2:0][2:0]   w_pp;
    logic [3:0]        w_pos;
    logic [3:0]        w_neg;
    logic [3:0]        w_prod;
    logic [3:0]        r_p_p1;

    assign w_a_g   = en ? a   : 2'b00;
    assign w_b_g   = en ? b   : 2'b00;
    assign w_sel_g = en ? sel : 2'b00;

    assign w_ax = f_ext(w_a_g, w_sel_g[0]);
    assign w_bx = f_ext(w_b_g, w_sel_g[1]);

    // AND array: w_pp[i][j] is bit i of A times bit j of B, with weight 2^(i+j).
    always_comb begin
        w_pp = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_pp[i][j] = w_ax[i] & w_bx[j];
            end
        end
    end

    // Sum the positive-weight terms. These are the magnitude bits of both operands.
    // The sign-by-sign term w_pp[2][2] has weight 16. It falls outside the 4-bit result, so it is dropped.
    always_comb begin
        w_pos = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                w_pos = w_pos + ({3'b000, w_pp[i][j]} << (i + j));
            end
        end
    end

    // Sum the negative-weight terms: the A sign row and the B sign column against the magnitude bits.
    always_comb begin
        w_neg = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            w_neg = w_neg + ({3'b000, w_pp[2][k]} << (k + 2));
            w_neg = w_neg + ({3'b000, w_pp[k][2]} << (k + 2));
        end
    end

    // Subtract the negative-weight sum with an explicit two's-complement add, modulo 16.
    assign w_prod = w_pos + (~w_neg + 4'd1);

    // --- stage boundary: registered product, 1-cycle latency ---
    // Result register: reset clears, en captures, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_p1 <= 4'b0000;
        end else if (en) begin
            r_p_p1 <= w_prod;
        end
    end

    assign p = r_p_p1;

endmodule

// File: tb/tb_m_bb.sv
// tb_m_bb: self-checking bench for the m_bb bit brick.
// Expected products come from integer arithmetic on the decoded operand values.
module tb_m_bb;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] sel;
    logic [3:0] p;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_p;

    m_bb dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (a),
        .b   (b),
        .sel (sel),
        .p   (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decode each operand to an integer, multiply, keep 4 bits.
    function automatic logic [3:0] ref_prod(input logic [1:0] s, input logic [1:0] va, input logic [1:0] vb);
        int ia;
        int ib;
        int prod;
        ia = int'(va);
        ib = int'(vb);
        if (s[0] && ia >= 2) ia = ia - 4;
        if (s[1] && ib >= 2) ib = ib - 4;
        prod = ia * ib;
        return prod[3:0];
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] expected);
        checks++;
        assert (p === expected)
        else begin
            errors++;
            $error("FAIL %s: p=%b expected=%b", tag, p, expected);
        end
    endtask

    // One enabled capture, then a check against a value supplied by the caller.
    task automatic capture(input logic [1:0] s, input logic [1:0] va, input logic [1:0] vb,
                           input logic [3:0] expected, input string tag);
        sel = s; a = va; b = vb; en = 1'b1;
        step();
        check(tag, expected);
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; a = 2'd3; b = 2'd3; sel = 2'b00;
        #1;

        // Reset, with en asserted, must win.
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_with_en", 4'b0000);
        end
        rst = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_reset_hold", 4'b0000);
        end

        // Exhaustive sweep. Hold is checked with random idle inputs after each capture.
        for (int s = 0; s < 4; s++) begin
            for (int ia = 0; ia < 4; ia++) begin
                for (int ib = 0; ib < 4; ib++) begin
                    exp_p = ref_prod(2'(s), 2'(ia), 2'(ib));
                    capture(2'(s), 2'(ia), 2'(ib), exp_p, "sweep");
                    a = 2'($urandom); b = 2'($urandom); sel = 2'($urandom);
                    step();
                    check("sweep_hold", exp_p);
                end
            end
        end

        // Boundary products.
        capture(2'b11, 2'b10, 2'b10, 4'b0100, "ss_max_pos");
        capture(2'b11, 2'b11, 2'b01, 4'b1111, "ss_minus1");
        capture(2'b01, 2'b10, 2'b11, 4'b1010, "su_min");
        capture(2'b10, 2'b11, 2'b10, 4'b1010, "us_min");
        capture(2'b00, 2'b11, 2'b11, 4'b1001, "uu_max");

        // Hold across random idle inputs, then reset together with en.
        for (int i = 0; i < 5; i++) begin
            a = 2'($urandom); b = 2'($urandom); sel = 2'($urandom);
            step();
            check("hold_9", 4'b1001);
        end
        rst = 1'b1; en = 1'b1; a = 2'd3; b = 2'd3; sel = 2'b00;
        step();
        check("rst_over_en", 4'b0000);
        rst = 1'b0; en = 1'b0;

        // Random mix of en, rst and operands, tracked by the model.
        exp_p = 4'b0000;
        for (int i = 0; i < 300; i++) begin
            en  = 1'($urandom);
            rst = ($urandom_range(0, 19) == 0);
            a   = 2'($urandom);
            b   = 2'($urandom);
            sel = 2'($urandom);
            if (rst) exp_p = 4'b0000;
            else if (en) exp_p = ref_prod(sel, a, b);
            step();
            check("random", exp_p);
        end
        rst = 1'b0; en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
